// File: rtl/multi_ball_engine.sv
// Multi-ball bouncing engine: sweeps a fixed obstacle once, then per frame
// erases, moves and redraws NUM_BALLS balls, one plot pixel per cycle.

module mb_ball_step #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int OBS_X0 = 70,
  parameter int OBS_X1 = 89,
  parameter int OBS_Y0 = 50,
  parameter int OBS_Y1 = 69
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           xd,
  input  logic           yd,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny,
  output logic           nxd,
  output logic           nyd
);
  localparam logic [X_W-1:0] XM  = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM  = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] OX0 = X_W'(OBS_X0);
  localparam logic [X_W-1:0] OX1 = X_W'(OBS_X1);
  localparam logic [Y_W-1:0] OY0 = Y_W'(OBS_Y0);
  localparam logic [Y_W-1:0] OY1 = Y_W'(OBS_Y1);

  function automatic logic in_obs(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
    return (px >= OX0) && (px <= OX1) && (py >= OY0) && (py <= OY1);
  endfunction

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           cxd, cyd, hx, hy, hd;

  always_comb begin
    // Wall rule first: reverse at the edge, then step in the new direction.
    if (xd && x == XM)           begin cxd = 1'b0; cx = x - 1'b1; end
    else if (!xd && x == '0)     begin cxd = 1'b1; cx = x + 1'b1; end
    else                         begin cxd = xd;   cx = xd ? x + 1'b1 : x - 1'b1; end
    if (yd && y == YM)           begin cyd = 1'b0; cy = y - 1'b1; end
    else if (!yd && y == '0)     begin cyd = 1'b1; cy = y + 1'b1; end
    else                         begin cyd = yd;   cy = yd ? y + 1'b1 : y - 1'b1; end

    hx = in_obs(cx, y);
    hy = in_obs(x, cy);
    hd = in_obs(cx, cy);

    nx = cx; nxd = cxd;
    ny = cy; nyd = cyd;
    if (hx) begin nx = x; nxd = ~cxd; end
    if (hy) begin ny = y; nyd = ~cyd; end
    // Pure diagonal corner contact: bounce back on both axes without moving.
    if (!hx && !hy && hd) begin
      nx = x; nxd = ~cxd;
      ny = y; nyd = ~cyd;
    end
  end
endmodule

module multi_ball_engine #(
  parameter int NUM_BALLS   = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int TICK_CYCLES = 833333,
  parameter int OBS_X0      = 70,
  parameter int OBS_X1      = 89,
  parameter int OBS_Y0      = 50,
  parameter int OBS_Y1      = 69
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  output logic [2:0]     color,
  output logic           plot,
  output logic           frame_done
);
  localparam int IDX_W  = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BALLS - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_CYCLES - 1);
  localparam logic [X_W-1:0] OX0 = X_W'(OBS_X0);
  localparam logic [X_W-1:0] OX1 = X_W'(OBS_X1);
  localparam logic [Y_W-1:0] OY0 = Y_W'(OBS_Y0);
  localparam logic [Y_W-1:0] OY1 = Y_W'(OBS_Y1);

  typedef enum logic [2:0] {S_OBS, S_DRAW, S_WAIT, S_ERASE, S_MOVE} state_t;

  state_t                          state;
  logic [X_W-1:0]                  ox;
  logic [Y_W-1:0]                  oy;
  logic [TICK_W-1:0]               tick;
  logic [IDX_W-1:0]                idx;
  logic [NUM_BALLS-1:0][X_W-1:0]   bx, nbx;
  logic [NUM_BALLS-1:0][Y_W-1:0]   by, nby;
  logic [NUM_BALLS-1:0]            bxd, byd, nbxd, nbyd;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    mb_ball_step #(
      .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
      .OBS_X0(OBS_X0), .OBS_X1(OBS_X1), .OBS_Y0(OBS_Y0), .OBS_Y1(OBS_Y1)
    ) u_step (
      .x(bx[g]), .y(by[g]), .xd(bxd[g]), .yd(byd[g]),
      .nx(nbx[g]), .ny(nby[g]), .nxd(nbxd[g]), .nyd(nbyd[g])
    );
  end

  // Each edge executes one step of `state` and registers that step's pixel,
  // so the outputs seen in a cycle belong to the step just taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_OBS;
      ox         <= OX0;
      oy         <= OY0;
      tick       <= '0;
      idx        <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
      xpos       <= '0;
      ypos       <= '0;
      color      <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        bx[i]  <= X_W'(1 + 8 * i);
        by[i]  <= Y_W'(1 + 4 * i);
        bxd[i] <= 1'b1;
        byd[i] <= 1'b1;
      end
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      xpos       <= '0;
      ypos       <= '0;
      color      <= '0;
      unique case (state)
        S_OBS: begin
          plot  <= 1'b1;
          xpos  <= ox;
          ypos  <= oy;
          color <= 3'b111;
          if (ox == OX1) begin
            ox <= OX0;
            if (oy == OY1) begin
              oy    <= OY0;
              idx   <= '0;
              state <= S_DRAW;
            end else begin
              oy <= oy + 1'b1;
            end
          end else begin
            ox <= ox + 1'b1;
          end
        end
        S_DRAW: begin
          plot  <= 1'b1;
          xpos  <= bx[idx];
          ypos  <= by[idx];
          color <= 3'((32'(idx) % 7) + 1);
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            idx        <= '0;
            tick       <= '0;
            state      <= S_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (run) begin
            if (tick == LAST_TICK) begin
              tick  <= '0;
              idx   <= '0;
              state <= S_ERASE;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        S_ERASE: begin
          plot <= 1'b1;
          xpos <= bx[idx];
          ypos <= by[idx];
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_MOVE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_MOVE: begin
          bx    <= nbx;
          by    <= nby;
          bxd   <= nbxd;
          byd   <= nbyd;
          idx   <= '0;
          state <= S_DRAW;
        end
        default: state <= S_OBS;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_ball_engine.sv
// Directed bench for multi_ball_engine: 2 balls in a 16x12 field, 2x2 obstacle,
// 4-cycle tick; checks every output cycle against hand-derived pixels.

module tb_multi_ball_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b1;
  logic [7:0] xpos;
  logic [6:0] ypos;
  logic [2:0] color;
  logic       plot;
  logic       frame_done;

  int n_vec = 0;
  int n_bad = 0;

  // Hand-derived ball positions per frame (frame 0 = first draw after sweep).
  int b0x [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int b0y [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int b1x [8] = '{9, 10, 11, 12, 13, 14, 15, 14};
  int b1y [8] = '{5, 6, 7, 8, 9, 10, 11, 10};

  always #5 clk = ~clk;

  multi_ball_engine #(
    .NUM_BALLS(2), .X_W(8), .Y_W(7), .X_MAX(15), .Y_MAX(11), .TICK_CYCLES(4),
    .OBS_X0(5), .OBS_X1(6), .OBS_Y0(3), .OBS_Y1(4)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .xpos(xpos), .ypos(ypos), .color(color), .plot(plot), .frame_done(frame_done)
  );

  logic [19:0] obs_v;
  assign obs_v = {plot, frame_done, color, xpos, ypos};

  function automatic logic [19:0] pk(input bit p, input bit fd, input int c, input int x, input int y);
    return {p, fd, 3'(c), 8'(x), 7'(y)};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {plot,fd,c,x,y}=%h want %h", tag, got, exp);
    end
  endtask

  task automatic px(input string tag, input int x, input int y, input int c, input bit fd);
    @(negedge clk);
    chk(tag, obs_v, pk(1'b1, fd, c, x, y));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    chk(tag, obs_v, pk(1'b0, 1'b0, 0, 0, 0));
  endtask

  task automatic obs_sweep();
    for (int y = 3; y <= 4; y++)
      for (int x = 5; x <= 6; x++)
        px("obs", x, y, 7, 1'b0);
  endtask

  // One full frame after a draw: wait, erase old positions, move, draw new.
  task automatic run_frame(input int f);
    for (int i = 0; i < 4; i++) idle("wait");
    px("erase0", b0x[f-1], b0y[f-1], 0, 1'b0);
    px("erase1", b1x[f-1], b1y[f-1], 0, 1'b0);
    idle("move");
    px("draw0", b0x[f], b0y[f], 1, 1'b0);
    px("draw1", b1x[f], b1y[f], 2, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b1;
    idle("reset_a");
    idle("reset_b");
    reset = 1'b1;

    obs_sweep();
    px("draw0_f0", 1, 1, 1, 1'b0);
    px("draw1_f0", 9, 5, 2, 1'b1);
    for (int f = 1; f < 8; f++) run_frame(f);

    // Freeze the frame timer after two counted WAIT cycles.
    idle("wait_c0");
    idle("wait_c1");
    run = 1'b0;
    for (int i = 0; i < 10; i++) idle("frozen");
    run = 1'b1;
    idle("wait_c2");
    idle("wait_c3");
    px("erase0_run", 1, 8, 0, 1'b0);

    // Reset lands on the step that would erase ball 1.
    reset = 1'b0;
    idle("reset_mid");
    reset = 1'b1;
    obs_sweep();
    px("draw0_rst", 1, 1, 1, 1'b0);
    px("draw1_rst", 9, 5, 2, 1'b1);
    run_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_ball_engine.md
Name: multi_ball_engine

Overview:
- Parametrised successor to the single-ball bouncing-object processor.
- Animates NUM_BALLS independent balls inside an X_MAX x Y_MAX pixel field containing one fixed rectangular obstacle.
- Emits one-pixel-per-cycle plot commands (xpos/ypos/color/plot) to the VGA adapter: obstacle once after reset, then per frame erase all balls, move all, draw all.
- Controller FSM plus per-ball position/direction registers in one block.

Parameters:
- NUM_BALLS, 4, number of balls (1..8).
- X_W, 8, xpos width.
- Y_W, 7, ypos width.
- X_MAX, 159, largest legal x.
- Y_MAX, 119, largest legal y.
- TICK_CYCLES, 833333, WAIT-state cycles per frame (60 Hz at 50 MHz); at least 1.
- OBS_X0, 70, obstacle left x (inclusive).
- OBS_X1, 89, obstacle right x (inclusive).
- OBS_Y0, 50, obstacle top y (inclusive).
- OBS_Y1, 69, obstacle bottom y (inclusive).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-low; a sampled 0 resets the block.
- run  in  1  1 = frame timer advances; 0 = timer frozen in WAIT.
- xpos  out  X_W  pixel x for current plot.
- ypos  out  Y_W  pixel y for current plot.
- color  out  3  pixel colour for current plot.
- plot  out  1  1 = write pixel (xpos,ypos,color) this cycle.
- frame_done  out  1  one-cycle pulse on the last DRAW cycle of each frame.

Behaviour:
- Reset (reset=0 at edge), from any state including mid-ERASE/DRAW:
  - state=OBS; obstacle sweep counters at (OBS_X0,OBS_Y0); tick counter=0.
  - Ball i: x=1+8i, y=1+4i, xdir=1 (right), ydir=1 (down).
  - Outputs while reset is held and in the cycle after: plot=0, frame_done=0, xpos=ypos=color=0.
  - Parameter legality: initial positions are on-screen and outside the obstacle; obstacle is inside the field.
- Output rule: plot=1 exactly in OBS, ERASE and DRAW states. Whenever plot=0, xpos/ypos/color=0. Outputs come from registered state and stay aligned with plot in the same cycle.
- OBS: one pixel per cycle, colour 3'b111, raster order (x inner OBS_X0..OBS_X1, y outer OBS_Y0..OBS_Y1). Lasts (OBS_X1-OBS_X0+1)*(OBS_Y1-OBS_Y0+1) cycles, then DRAW.
- DRAW: N cycles; cycle k plots ball k at its current position, colour (k mod 7)+1. frame_done=1 on cycle N-1. Next state WAIT, tick counter cleared.
- WAIT:
  - plot=0. If run=1 the counter increments; if run=0 it holds.
  - When counter==TICK_CYCLES-1 and run=1, go to ERASE. WAIT therefore lasts exactly TICK_CYCLES cycles with run held high.
- ERASE: N cycles; cycle k plots ball k at its current position, colour 3'b000, then MOVE.
- MOVE: one cycle, plot=0; all balls update in parallel, each axis independently:
  - Wall: if (dir=1 and pos==MAX) or (dir=0 and pos==0), flip dir, then step one in the new direction.
  - Otherwise candidate nx=x±1, ny=y±1.
  - Obstacle, checked after the wall rule:
    - (nx,y) inside obstacle: flip xdir, x unchanged.
    - (x,ny) inside obstacle: flip ydir, y unchanged.
    - If neither single-axis candidate is inside but (nx,ny) is (diagonal corner hit): flip both dirs, neither coordinate moves.
  - Balls do not interact. Overlapping balls are legal; higher index wins in DRAW.
  - Next state DRAW.
- Frame period after the first: TICK_CYCLES + 2N + 1 cycles (run held high).
- Arithmetic: positions are unsigned and never leave 0..MAX. Comparisons use full X_W/Y_W widths.

Test Plan:
- All tests use NUM_BALLS=2, X_MAX=15, Y_MAX=11, TICK_CYCLES=4, obstacle x5..6, y3..4, run=1.
- Reset release -> plots (5,3),(6,3),(5,4),(6,4) colour 7; then (1,1) c1, (9,5) c2 with frame_done on the second; 4 idle cycles; erase (1,1),(9,5) c0; 1 idle; draw (2,2),(10,6). Frame period is 9 cycles.
- Obstacle bounce: ball0 frames (2,2),(3,3),(4,4) -> next frame (4,5) with xdir=0 -> then (3,6).
- Corner/wall bounce: ball1 reaches (15,11) at frame 6 -> frame 7 draws (14,10), both dirs 0.
- run=0 for 10 cycles mid-WAIT after 2 counted cycles -> no plot pulses, counter holds; after run=1, ERASE starts exactly 2 cycles later.
- reset=0 for 1 cycle during the ERASE of ball1 -> plot=0 the following cycle; after release, full obstacle sweep repeats and balls redraw at (1,1),(9,5).
